// File: rtl/volume_history_pkg.sv
// Shared widths, constants and types for the mic volume history block.
// Also holds the sample-to-magnitude helper.
package volume_history_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int MIDPOINT  = 2048;
  localparam int NUM_SLOTS = 16;
  localparam int LEVEL_W   = 5;
  localparam int LVL_W     = 4;
  localparam int MAG_W     = 11;
  localparam int MAG_MAX   = 2047;
  localparam int HIST_W    = NUM_SLOTS * LEVEL_W;

  typedef logic [HIST_W-1:0] hist_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } state_e;

  function automatic logic [MAG_W-1:0] mag_of(
    input logic [SAMPLE_W-1:0] s
  );
    logic [SAMPLE_W-1:0] d;
    if (s >= SAMPLE_W'(MIDPOINT))
      d = s - SAMPLE_W'(MIDPOINT);
    else
      d = SAMPLE_W'(MIDPOINT) - s;
    // Only sample 0 reaches 2048 below midpoint.
    if (d > SAMPLE_W'(MAG_MAX))
      return MAG_W'(MAG_MAX);
    return d[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/volume_history_if.sv
// Sample-in / history-out bundle for volume_history.
// master drives samples, slave is the history block.
interface volume_history_if;
  import volume_history_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                freeze;
  hist_t               volume;
  logic [LVL_W-1:0]    level;
  logic                slot_update;

  modport master (
    output sample_valid, sample, freeze,
    input  volume, level, slot_update
  );

  modport slave (
    input  sample_valid, sample, freeze,
    output volume, level, slot_update
  );

endinterface

// File: rtl/abs_peak_window.sv
// Peak deviation from midpoint over a fixed window of samples.
// Emits the quantised window level and a window-complete strobe.
module abs_peak_window
  import volume_history_pkg::*;
#(
  parameter int WINDOW = 4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [LVL_W-1:0]    pending_o,
  output logic                window_done_o
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [LVL_W-1:0] pend_q, pend_d;
  logic [MAG_W-1:0] mag, pk;

  always_comb begin
    mag = mag_of(sample_i);
    pk  = (mag > peak_q) ? mag : peak_q;
    window_done_o = sample_valid_i && (count_q == LAST);
    count_d = count_q;
    peak_d  = peak_q;
    pend_d  = pend_q;
    if (window_done_o) begin
      count_d = '0;
      peak_d  = '0;
      pend_d  = pk[MAG_W-1 -: LVL_W];
    end else if (sample_valid_i) begin
      count_d = count_q + 1'b1;
      peak_d  = pk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      peak_q  <= '0;
      pend_q  <= '0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      pend_q  <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/volume_history.sv
// Volume history: one quantised peak level per window,
// shifted into a 16-slot history (slot 0 oldest, slot 15 newest).
module volume_history
  import volume_history_pkg::*;
#(
  parameter int WINDOW = 4000
) (
  input logic              clk,
  input logic              reset,
  volume_history_if.slave  bus
);

  state_e           state_q, state_d;
  hist_t            volume_q, volume_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             slot_update_q, slot_update_d;
  logic [LVL_W-1:0] pending;
  logic             window_done;

  abs_peak_window #(
    .WINDOW(WINDOW)
  ) u_apw (
    .clk           (clk),
    .reset         (reset),
    .sample_valid_i(bus.sample_valid),
    .sample_i      (bus.sample),
    .pending_o     (pending),
    .window_done_o (window_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ACCUM;
    unique case (state_q)
      ACCUM:   state_d = window_done ? COMMIT : ACCUM;
      COMMIT:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    volume_d      = volume_q;
    level_d       = level_q;
    slot_update_d = 1'b0;
    if (state_q == COMMIT) begin
      level_d = pending;
      // A frozen display keeps its bars but still tracks the live level.
      if (!bus.freeze) begin
        volume_d      = {1'b0, pending, volume_q[HIST_W-1:LEVEL_W]};
        slot_update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      volume_q      <= '0;
      level_q       <= '0;
      slot_update_q <= 1'b0;
    end else begin
      volume_q      <= volume_d;
      level_q       <= level_d;
      slot_update_q <= slot_update_d;
    end
  end

  assign bus.volume      = volume_q;
  assign bus.level       = level_q;
  assign bus.slot_update = slot_update_q;

endmodule
